// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    PORT_CORE,
    PORT_EXT
  } arb_port_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data memory.
// Every access is a fixed ISSUE/RESP pair so the memory's registered read
// lands in RESP, where it is captured into the owner's rdata register.
module dmem_arbiter #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned D_ADDR_W = 8
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                core_req,
  input  logic                core_wr,
  input  logic [D_ADDR_W-1:0] core_addr,
  input  logic [WIDTH-1:0]    core_wdata,
  output logic [WIDTH-1:0]    core_rdata,
  output logic                core_ack,

  input  logic                ext_req,
  input  logic                ext_wr,
  input  logic [D_ADDR_W-1:0] ext_addr,
  input  logic [WIDTH-1:0]    ext_wdata,
  output logic [WIDTH-1:0]    ext_rdata,
  output logic                ext_ack,
  input  logic                ext_lock,

  output logic                mem_write,
  output logic [D_ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]    mem_wdata,
  input  logic [WIDTH-1:0]    mem_rdata,

  output logic                busy
);

  import dmem_arb_pkg::*;

  arb_state_t state;
  arb_port_t  owner;
  arb_port_t  last;
  logic       lock_q;
  logic       op_wr;

  arb_port_t             win_c;
  logic                  sel_wr_c;
  logic [D_ADDR_W-1:0]   sel_addr_c;
  logic [WIDTH-1:0]      sel_wdata_c;

  // Pick the winner among current requests and mux its request fields.
  always_comb begin
    win_c       = PORT_CORE;
    sel_wr_c    = core_wr;
    sel_addr_c  = core_addr;
    sel_wdata_c = core_wdata;
    if (ext_req && (!core_req || lock_q || (last == PORT_CORE))) begin
      win_c = PORT_EXT;
    end
    if (win_c == PORT_EXT) begin
      sel_wr_c    = ext_wr;
      sel_addr_c  = ext_addr;
      sel_wdata_c = ext_wdata;
    end
  end

  // Arbitration FSM; memory bus and acks are registered and default low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ARB_IDLE;
      owner      <= PORT_CORE;
      last       <= PORT_EXT;
      lock_q     <= 1'b0;
      op_wr      <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_ack   <= 1'b0;
      ext_ack    <= 1'b0;
      core_rdata <= '0;
      ext_rdata  <= '0;
      busy       <= 1'b0;
    end else begin
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      core_ack  <= 1'b0;
      ext_ack   <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (core_req || ext_req) begin
            owner     <= win_c;
            op_wr     <= sel_wr_c;
            mem_write <= sel_wr_c;
            mem_addr  <= sel_addr_c;
            mem_wdata <= sel_wdata_c;
            busy      <= 1'b1;
            state     <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (owner == PORT_EXT) begin
            ext_ack <= 1'b1;
          end else begin
            core_ack <= 1'b1;
          end
          state <= ARB_RESP;
        end
        ARB_RESP: begin
          if (!op_wr) begin
            if (owner == PORT_EXT) begin
              ext_rdata <= mem_rdata;
            end else begin
              core_rdata <= mem_rdata;
            end
          end
          last   <= owner;
          lock_q <= (owner == PORT_EXT) ? ext_lock : 1'b0;
          busy   <= 1'b0;
          state  <= ARB_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule
